// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between the fetch path and the
// data path. Data requests win arbitration unless a pending fetch has already
// lost IMAX_WAIT consecutive decisions. Each access is latched on grant so the
// RAM sees stable address/data/strobes for the full access.
module memory_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int IMAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(IMAX_WAIT);
    localparam logic [3:0] STARVE_MAX   = 4'hF;

    state_t            state;
    state_t            next_state;
    logic [3:0]        starve;
    logic [3:0]        starve_next;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_wr;
    logic              dreq;

    assign dreq = dREN | dWEN;

    // State register; reset abandons any in-flight access immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration, starvation accounting and per-state output decode.
    always_comb begin
        next_state  = state;
        starve_next = starve;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        iload       = '0;
        dwait       = 1'b1;
        dload       = '0;
        case (state)
            IDLE: begin
                if (dreq && ((starve < STARVE_LIMIT) || !iREN)) begin
                    next_state = DACC;
                    // A waiting fetch just lost another round; count it.
                    if (iREN) begin
                        starve_next = (starve == STARVE_MAX) ? starve : starve + 4'd1;
                    end else begin
                        starve_next = '0;
                    end
                end else if (iREN) begin
                    next_state  = IACC;
                    starve_next = '0;
                end else begin
                    starve_next = '0;
                end
            end
            IACC: begin
                ramREN   = 1'b1;
                ramaddr  = lat_addr;
                ramstore = lat_data;
                if (ramready) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    next_state = IDLE;
                end
            end
            DACC: begin
                ramREN   = ~lat_wr;
                ramWEN   = lat_wr;
                ramaddr  = lat_addr;
                ramstore = lat_data;
                if (ramready) begin
                    dwait = 1'b0;
                    if (!lat_wr) begin
                        dload = ramload;
                    end
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Starvation counter for the fetch side.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve <= '0;
        end else begin
            starve <= starve_next;
        end
    end

    // Capture the winning request on grant; a write wins over a read when both are high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
        end else if (state == IDLE) begin
            if (next_state == DACC) begin
                lat_addr <= daddr;
                lat_data <= dstore;
                lat_wr   <= dWEN;
            end else if (next_state == IACC) begin
                lat_addr <= iaddr;
                lat_data <= '0;
                lat_wr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_memory_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int IMAX_WAIT = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              iREN = 1'b0;
    logic [ADDR_W-1:0] iaddr = '0;
    logic [DATA_W-1:0] iload;
    logic              iwait;
    logic              dREN = 1'b0;
    logic              dWEN = 1'b0;
    logic [ADDR_W-1:0] daddr = '0;
    logic [DATA_W-1:0] dstore = '0;
    logic [DATA_W-1:0] dload;
    logic              dwait;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload = '0;
    logic              ramready = 1'b0;

    int checks   = 0;
    int failures = 0;

    memory_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .IMAX_WAIT(IMAX_WAIT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iload   (iload),
        .iwait   (iwait),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dload   (dload),
        .dwait   (dwait),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Model of the arbiter at transaction level: who owns the RAM, what was
    // captured on grant, and how many rounds the fetch side has lost in a row.
    int          m_owner;   // 0 = nobody, 1 = fetch, 2 = data
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_wr;
    int          m_losses;

    initial begin
        logic [7:0] grants[$];
        string      exp_seq;
        logic       e_ren, e_wen, e_iwait, e_dwait, done;
        logic [31:0] e_iload, e_dload;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_ramREN", 64'(ramREN), 0);
        chk("rst_ramWEN", 64'(ramWEN), 0);
        chk("rst_ramaddr", 64'(ramaddr), 0);
        chk("rst_ramstore", 64'(ramstore), 0);
        chk("rst_iwait", 64'(iwait), 1);
        chk("rst_dwait", 64'(dwait), 1);
        chk("rst_iload", 64'(iload), 0);
        chk("rst_dload", 64'(dload), 0);
        RST = 1'b0;

        // ---- lone fetch, ramready two cycles after the strobe ----
        tick(); iREN = 1'b1; iaddr = 32'h0000_0040; #1;
        chk("lf_c0_ramREN", 64'(ramREN), 0);
        tick(); #1;
        chk("lf_c1_ramREN", 64'(ramREN), 1);
        chk("lf_c1_ramaddr", 64'(ramaddr), 32'h40);
        chk("lf_c1_iwait", 64'(iwait), 1);
        tick(); #1;
        chk("lf_c2_ramREN", 64'(ramREN), 1);
        chk("lf_c2_iwait", 64'(iwait), 1);
        tick(); ramready = 1'b1; ramload = 32'h8C22_0004; #1;
        chk("lf_c3_iwait", 64'(iwait), 0);
        chk("lf_c3_iload", 64'(iload), 32'h8C22_0004);
        tick(); ramready = 1'b0; iREN = 1'b0; #1;
        chk("lf_c4_ramREN", 64'(ramREN), 0);
        chk("lf_c4_iwait", 64'(iwait), 1);
        chk("lf_c4_iload", 64'(iload), 0);

        // ---- simultaneous requests: data first, then fetch ----
        tick(); iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; #1;
        chk("sim_c0_ramREN", 64'(ramREN), 0);
        tick(); #1;
        chk("sim_c1_ramaddr", 64'(ramaddr), 32'h100);
        chk("sim_c1_ramREN", 64'(ramREN), 1);
        chk("sim_c1_iwait", 64'(iwait), 1);
        chk("sim_c1_starve", 64'(dut.starve), 1);
        tick(); ramready = 1'b1; ramload = 32'h1234_5678; #1;
        chk("sim_c2_dwait", 64'(dwait), 0);
        chk("sim_c2_dload", 64'(dload), 32'h1234_5678);
        chk("sim_c2_iwait", 64'(iwait), 1);
        chk("sim_c2_iload", 64'(iload), 0);
        tick(); ramready = 1'b0; dREN = 1'b0; #1;
        chk("sim_c3_starve", 64'(dut.starve), 1);
        chk("sim_c3_ramREN", 64'(ramREN), 0);
        tick(); ramready = 1'b1; ramload = 32'hAAAA_5555; #1;
        chk("sim_c4_ramaddr", 64'(ramaddr), 32'h44);
        chk("sim_c4_iwait", 64'(iwait), 0);
        chk("sim_c4_iload", 64'(iload), 32'hAAAA_5555);
        chk("sim_c4_dwait", 64'(dwait), 1);
        tick(); ramready = 1'b0; iREN = 1'b0; #1;
        chk("sim_c5_starve", 64'(dut.starve), 0);

        // ---- starvation bound: IMAX_WAIT data grants, then the fetch ----
        tick(); iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h180; ramready = 1'b1; #1;
        for (int c = 0; c < 14; c++) begin
            if (ramREN && ramaddr == 32'h80) grants.push_back("I");
            else if (ramREN && ramaddr == 32'h180) grants.push_back("D");
            tick();
        end
        iREN = 1'b0; dREN = 1'b0; ramready = 1'b0;
        exp_seq = "DDDDID";
        chk("starve_ngrants_ok", 64'(grants.size() >= 6), 1);
        for (int g = 0; g < 6; g++) begin
            if (g < grants.size()) chk($sformatf("starve_grant%0d", g), 64'(grants[g]), 64'(exp_seq[g]));
        end
        tick(); tick(); #1;

        // ---- write priority and request latching ----
        tick(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; #1;
        tick(); daddr = 32'h300; dstore = 32'h0; #1;
        chk("wr_c1_ramWEN", 64'(ramWEN), 1);
        chk("wr_c1_ramREN", 64'(ramREN), 0);
        chk("wr_c1_ramaddr", 64'(ramaddr), 32'h200);
        chk("wr_c1_ramstore", 64'(ramstore), 32'hDEAD_BEEF);
        tick(); #1;
        chk("wr_c2_ramaddr", 64'(ramaddr), 32'h200);
        chk("wr_c2_ramstore", 64'(ramstore), 32'hDEAD_BEEF);
        tick(); ramready = 1'b1; ramload = 32'h7777_7777; #1;
        chk("wr_c3_dwait", 64'(dwait), 0);
        chk("wr_c3_dload", 64'(dload), 0);
        chk("wr_c3_ramWEN", 64'(ramWEN), 1);
        tick(); ramready = 1'b0; dREN = 1'b0; dWEN = 1'b0; #1;
        chk("wr_c4_ramWEN", 64'(ramWEN), 0);

        // ---- data read withdrawn mid-access, pending fetch served next ----
        tick(); dREN = 1'b1; daddr = 32'h500; iREN = 1'b1; iaddr = 32'h48; #1;
        tick(); dREN = 1'b0; #1;
        chk("wd_c1_ramREN", 64'(ramREN), 1);
        chk("wd_c1_ramaddr", 64'(ramaddr), 32'h500);
        tick(); #1;
        chk("wd_c2_ramREN", 64'(ramREN), 1);
        tick(); ramready = 1'b1; ramload = 32'h0BAD_F00D; #1;
        chk("wd_c3_dwait", 64'(dwait), 0);
        chk("wd_c3_ramREN", 64'(ramREN), 1);
        tick(); ramready = 1'b0; #1;
        chk("wd_c4_ramREN", 64'(ramREN), 0);
        tick(); ramready = 1'b1; ramload = 32'h1357_9BDF; #1;
        chk("wd_c5_ramaddr", 64'(ramaddr), 32'h48);
        chk("wd_c5_iwait", 64'(iwait), 0);
        chk("wd_c5_iload", 64'(iload), 32'h1357_9BDF);
        tick(); ramready = 1'b0; iREN = 1'b0; #1;

        // ---- asynchronous reset in the middle of a write ----
        tick(); dWEN = 1'b1; daddr = 32'h600; dstore = 32'h55; #1;
        tick(); #1;
        chk("ar_pre_ramWEN", 64'(ramWEN), 1);
        #1 RST = 1'b1;
        #1;
        chk("ar_ramWEN", 64'(ramWEN), 0);
        chk("ar_dwait", 64'(dwait), 1);
        dWEN = 1'b0;
        tick(); tick(); RST = 1'b0; #1;
        tick(); #1;
        chk("ar_post_ramREN", 64'(ramREN), 0);
        chk("ar_post_ramWEN", 64'(ramWEN), 0);
        chk("ar_post_iwait", 64'(iwait), 1);
        chk("ar_post_dwait", 64'(dwait), 1);

        // ---- randomized traffic against the model ----
        m_owner = 0; m_addr = '0; m_data = '0; m_wr = 1'b0; m_losses = 0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            iREN     = ($urandom_range(0, 99) < 60);
            dREN     = ($urandom_range(0, 99) < 45);
            dWEN     = ($urandom_range(0, 99) < 30);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramready = ($urandom_range(0, 99) < 40);
            #1;
            done    = (m_owner != 0) && ramready;
            e_ren   = (m_owner == 1) || (m_owner == 2 && !m_wr);
            e_wen   = (m_owner == 2) && m_wr;
            e_iwait = !(m_owner == 1 && ramready);
            e_dwait = !(m_owner == 2 && ramready);
            e_iload = (m_owner == 1 && ramready) ? ramload : 32'h0;
            e_dload = (m_owner == 2 && ramready && !m_wr) ? ramload : 32'h0;
            chk("rnd_ramREN", 64'(ramREN), 64'(e_ren));
            chk("rnd_ramWEN", 64'(ramWEN), 64'(e_wen));
            chk("rnd_iwait", 64'(iwait), 64'(e_iwait));
            chk("rnd_dwait", 64'(dwait), 64'(e_dwait));
            chk("rnd_iload", 64'(iload), 64'(e_iload));
            chk("rnd_dload", 64'(dload), 64'(e_dload));
            if (m_owner != 0) chk("rnd_ramaddr", 64'(ramaddr), 64'(m_addr));
            if (m_owner == 2) chk("rnd_ramstore", 64'(ramstore), 64'(m_data));
            // advance the model to what the next edge decides
            if (m_owner == 0) begin
                if ((dREN || dWEN) && !(iREN && m_losses >= IMAX_WAIT)) begin
                    m_owner  = 2;
                    m_addr   = daddr;
                    m_data   = dstore;
                    m_wr     = dWEN;
                    m_losses = iREN ? ((m_losses < 15) ? m_losses + 1 : 15) : 0;
                end else if (iREN) begin
                    m_owner  = 1;
                    m_addr   = iaddr;
                    m_wr     = 1'b0;
                    m_losses = 0;
                end else begin
                    m_losses = 0;
                end
            end else if (done) begin
                m_owner = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-ported unified RAM between the instruction-fetch path (icache side) and the data-memory path (dcache side) of the pipelined MIPS core.
- Serializes requests through a small FSM, holds each requester in wait until its access completes, and gives data priority with a bounded-starvation guarantee for fetch.
- Its iwait/dwait outputs become the ihit/dhit inputs that drive pipeline enables and stalls in the hazard logic.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.
- IMAX_WAIT, 4, consecutive arbitration losses after which a pending fetch is forced to win (range 1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- iREN  in  1  instruction read request; level, held until iwait low.
- iaddr  in  ADDR_W  instruction address.
- iload  out  DATA_W  instruction read data, valid when iREN & !iwait.
- iwait  out  1  fetch not complete.
- dREN  in  1  data read request; level.
- dWEN  in  1  data write request; level.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  read data, valid when dREN & !dwait.
- dwait  out  1  data access not complete.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data, valid with ramready.
- ramready  in  1  RAM access complete this cycle; arbitrary latency >= 1 cycle.

Behaviour:
- Reset values: FSM = IDLE, starve counter = 0, latched request = 0; ramREN = ramWEN = 0, ramaddr = ramstore = 0, iwait = dwait = 1, iload = dload = 0. Reset is asynchronous: a mid-access assertion drops the RAM strobes immediately and abandons the transfer.
- States: IDLE, IACC, DACC.
- IDLE arbitration, evaluated at the clock edge:
  - dreq = dREN | dWEN.
  - If dreq and (starve < IMAX_WAIT or !iREN): go to DACC.
  - Else if iREN: go to IACC.
  - Else: stay in IDLE.
- Starve counter:
  - +1 (saturating) at each IDLE decision where iREN = 1 and DACC is chosen.
  - Cleared on entry to IACC.
  - Cleared when iREN = 0 in IDLE.
- Request latch: on entry to IACC or DACC, latch the address, write data, and operation. If dREN & dWEN are both high, the op is a write. ramaddr, ramstore, ramREN and ramWEN are driven from the latch for the whole ACC state, so they stay stable even if the requester changes inputs.
- IACC: ramREN = 1, ramWEN = 0. In the ramready cycle: iwait = 0 and iload = ramload (combinational pass-through); next state is IDLE.
- DACC: ramREN or ramWEN per the latched op. In the ramready cycle: dwait = 0, and for a read dload = ramload; next state is IDLE.
- In IDLE, and for the non-granted requester, wait = 1 and load = 0.
- Latency: request sampled in IDLE at edge 0; RAM strobes asserted from cycle 1; completion in the ramready cycle k >= 1; IDLE at k+1; the next grant can start at k+2. The IDLE bubble between accesses is intentional.
- Request withdrawn mid-access: the RAM access still completes (no torn writes). The wait output still drops in the completion cycle, and the requester ignores it.
- ramready seen in IDLE: ignored.
- No request in IDLE: all RAM strobes are 0.

Test Plan:
- Reset mid-DACC write: RST asserted while ramWEN = 1 -> ramWEN = 0 in the same cycle; after release the FSM is IDLE and iwait = dwait = 1.
- Lone fetch: iREN = 1, iaddr = 0x0000_0040, RAM returns 0x8C22_0004 with ramready 2 cycles after the strobe -> ramREN = 1 with ramaddr = 0x40 from cycle 1; iwait = 0 and iload = 0x8C22_0004 exactly in the ramready cycle; IDLE the cycle after.
- Simultaneous requests: iREN = 1, dREN = 1 (daddr = 0x100) in the same cycle -> DACC first, dload returned; IACC follows; the starve counter reads 1 before the fetch grant.
- Starvation bound: iREN held high while dREN is re-asserted every IDLE, IMAX_WAIT = 4 -> exactly 4 DACC grants, then IACC, then the data request is served again.
- Write priority and latching: dREN = dWEN = 1, daddr = 0x200, dstore = 0xDEAD_BEEF, then daddr changed to 0x300 during DACC -> ramWEN = 1, ramREN = 0, ramaddr stays 0x200 and ramstore stays 0xDEAD_BEEF until ramready.
- Withdrawn request: dREN dropped one cycle into a DACC read -> ramREN is held until ramready; the FSM returns to IDLE and then grants a pending iREN.
